// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM encoding and the NOP word.
// Imported by fetch_stage and pc_reg; IF/ID uses the same NOP constant.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// 32-bit load-enabled register with async active-high reset to RESET_VAL.
// Ports: clk, rst, en (load), d (next value), q (current value).
module pc_reg
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, runs the imem read handshake, feeds IF/ID.
// Ports: clk/rst, stall_in, redirect(+target), imem_* handshake, ifid_en/flush, pc/instr out.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_load;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;

  logic [31:0] hold_buf;
  logic        hold_load;
  logic        squash, squash_next;
  logic [31:0] squash_target, squash_target_next;

  logic        in_fetch, in_hold;
  logic        instr_valid;

  assign tgt      = word_align(redirect_target);
  assign pc_plus4 = pc + 32'd4;
  assign in_fetch = (state == FETCH);
  assign in_hold  = (state == HOLD);

  assign instr_valid = (in_fetch & imem_resp & ~squash & ~redirect)
                     | (in_hold & ~redirect);

  assign ifid_en    = ~stall_in | redirect;
  assign ifid_flush = ifid_en & (redirect | ~instr_valid);

  assign imem_read    = in_fetch;
  assign imem_address = pc;
  assign pc_out       = pc;
  assign pc_plus4_out = pc_plus4;
  assign instr_out    = in_hold ? hold_buf : imem_rdata;

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk(clk),
    .rst(rst),
    .en (pc_load),
    .d  (pc_next),
    .q  (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_buf      <= NOP_INSTR;
      squash        <= 1'b0;
      squash_target <= 32'h0;
    end else begin
      state         <= state_next;
      squash        <= squash_next;
      squash_target <= squash_target_next;
      if (hold_load) begin
        hold_buf <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_next         = state;
    pc_load            = 1'b0;
    pc_next            = pc;
    hold_load          = 1'b0;
    squash_next        = squash;
    squash_target_next = squash_target;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_resp) begin
          if (redirect) begin
            pc_load     = 1'b1;
            pc_next     = tgt;
            squash_next = 1'b0;
          end else if (squash) begin
            pc_load     = 1'b1;
            pc_next     = squash_target;
            squash_next = 1'b0;
          end else if (stall_in) begin
            hold_load  = 1'b1;
            state_next = HOLD;
          end else begin
            pc_load = 1'b1;
            pc_next = pc_plus4;
          end
        end else if (redirect) begin
          // Address must stay put until the response; remember where to go.
          squash_next        = 1'b1;
          squash_target_next = tgt;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = tgt;
          state_next = FETCH;
        end else if (!stall_in) begin
          pc_load    = 1'b1;
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic.
// Checks the delivered instruction stream against program order and redirects.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        ifid_en;
  logic        ifid_flush;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;

  fetch_stage #(.RESET_PC(32'h60)) dut (
    .clk(clk),
    .rst(rst),
    .stall_in(stall_in),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .imem_read(imem_read),
    .imem_address(imem_address),
    .imem_resp(imem_resp),
    .imem_rdata(imem_rdata),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out),
    .instr_out(instr_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model
  int lat = 1;
  int cnt = 0;
  bit rnd = 0;

  // architectural reference: next PC in program order
  logic [31:0] exp_pc;
  logic        p_read, p_resp;
  logic [31:0] p_addr;
  int          idle;
  int          captures;

  // snapshot of the last cycle
  logic        o_read, o_resp, o_en, o_flush;
  logic [31:0] o_addr, o_pc, o_p4, o_instr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5671;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h60;
    p_read = 1'b0;
    p_resp = 1'b0;
    p_addr = 32'h0;
    idle   = 0;
  endtask

  task automatic monitor(input logic st, input logic rd, input logic [31:0] tg);
    logic cap;
    chk("ifid_en", {31'b0, ifid_en}, {31'b0, ~st | rd});
    chk("pc_plus4", pc_plus4_out, pc_out + 32'd4);
    if (imem_read && p_read && !p_resp)
      chk("addr_stable", imem_address, p_addr);
    else if (imem_read)
      chk("req_addr", imem_address, exp_pc);
    if (rd)
      chk("redir_flush", {31'b0, ifid_flush}, 32'd1);
    cap = ifid_en && !ifid_flush;
    if (cap) begin
      chk("cap_pc", pc_out, exp_pc);
      chk("cap_instr", instr_out, word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      captures++;
    end
    if (rd) exp_pc = tg & ~32'h3;
    if (cap || st || rd) idle = 0;
    else idle++;
    if (idle > 12) begin
      chk("progress", 32'(idle), 32'd12);
      idle = 0;
    end
    p_read = imem_read;
    p_resp = imem_resp;
    p_addr = imem_address;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    stall_in        = st;
    redirect        = rd;
    redirect_target = tg;
    if (rnd && cnt == 0) lat = $urandom_range(1, 4);
    imem_resp  = imem_read && (cnt + 1 >= lat);
    imem_rdata = imem_resp ? word(imem_address) : 32'hDEAD_BEEF;
    @(negedge clk);
    o_read  = imem_read;
    o_resp  = imem_resp;
    o_en    = ifid_en;
    o_flush = ifid_flush;
    o_addr  = imem_address;
    o_pc    = pc_out;
    o_p4    = pc_plus4_out;
    o_instr = instr_out;
    if (!rst) monitor(st, rd, tg);
    if (imem_read && !imem_resp) cnt++;
    else cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    stall_in = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    imem_resp = 1'b0;
    imem_rdata = 32'h0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_read", {31'b0, imem_read}, 32'd0);
      chk("rst_addr", imem_address, 32'h60);
      chk("rst_pc", pc_out, 32'h60);
      chk("rst_p4", pc_plus4_out, 32'h64);
      chk("rst_en", {31'b0, ifid_en}, 32'd1);
      chk("rst_flush", {31'b0, ifid_flush}, 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    captures = 0;
    model_reset();
    rst = 1'b1;
    #1;
    do_reset(3);

    // sequential fetch, 1-cycle memory
    lat = 1;
    step(0, 0, 0);
    chk("first_idle_read", {31'b0, o_read}, 32'd0);
    step(0, 0, 0);
    chk("f60_read", {31'b0, o_read}, 32'd1);
    chk("f60_addr", o_addr, 32'h60);
    chk("f60_flush", {31'b0, o_flush}, 32'd0);
    chk("f60_p4", o_p4, 32'h64);
    step(0, 0, 0);
    chk("f64_addr", o_addr, 32'h64);
    chk("f64_p4", o_p4, 32'h68);
    step(0, 0, 0);
    chk("f68_addr", o_addr, 32'h68);
    chk("f68_p4", o_p4, 32'h6C);

    // stall while the 0x64 word arrives
    do_reset(1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("st_resp_addr", o_addr, 32'h64);
    chk("st_resp_en", {31'b0, o_en}, 32'd0);
    step(1, 0, 0);
    chk("hold_read", {31'b0, o_read}, 32'd0);
    chk("hold_en", {31'b0, o_en}, 32'd0);
    step(1, 0, 0);
    chk("hold_read2", {31'b0, o_read}, 32'd0);
    step(0, 0, 0);
    chk("rel_flush", {31'b0, o_flush}, 32'd0);
    chk("rel_pc", o_pc, 32'h64);
    chk("rel_instr", o_instr, word(32'h64));
    step(0, 0, 0);
    chk("after_hold_addr", o_addr, 32'h68);
    chk("after_hold_flush", {31'b0, o_flush}, 32'd0);

    // redirect in flight, 4-cycle memory
    lat = 4;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("f6c_pc", o_pc, 32'h6C);
    step(0, 0, 0);
    chk("f70_addr", o_addr, 32'h70);
    step(0, 1, 32'h200);
    chk("rif_flush", {31'b0, o_flush}, 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rif_resp", {31'b0, o_resp}, 32'd1);
    chk("rif_drop", {31'b0, o_flush}, 32'd1);
    step(0, 0, 0);
    chk("rif_next", o_addr, 32'h200);

    // redirect with response and stall together
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 32'h100);
    chk("rr_resp", {31'b0, o_resp}, 32'd1);
    chk("rr_en", {31'b0, o_en}, 32'd1);
    chk("rr_flush", {31'b0, o_flush}, 32'd1);
    step(0, 0, 0);
    chk("rr_next", o_addr, 32'h100);

    // two redirects during one outstanding fetch
    step(0, 1, 32'h300);
    step(0, 1, 32'h403);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("dr_next", o_addr, 32'h400);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("dr_cap", o_pc, 32'h400);
    chk("dr_cap_flush", {31'b0, o_flush}, 32'd0);

    // wrap-around
    step(0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 0);
    chk("wr_addr", o_addr, 32'hFFFF_FFFC);
    chk("wr_p4", o_p4, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 0);
    chk("wr_next", o_addr, 32'h0);

    // reset with a squash pending mid-request
    step(0, 1, 32'h500);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_read", {31'b0, imem_read}, 32'd0);
    chk("mrst_addr", imem_address, 32'h60);
    @(posedge clk);
    #1;
    do_reset(1);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("mrst_cap_pc", o_pc, 32'h60);
    chk("mrst_cap_flush", {31'b0, o_flush}, 32'd0);
    step(0, 0, 0);
    chk("mrst_next", o_addr, 32'h64);

    // random traffic against the stream model
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      logic st, rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 15) == 0);
      tg = $urandom;
      if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF8 | (tg & 32'h7);
      step(st, rd, tg);
    end
    chk("rand_progress", {31'b0, captures > 500}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
